mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single port of the unified instruction/data memory between the multi-cycle CPU (port 0) and the program loader / debug DMA (port 1). It owns the memory address, write-data and write-enable lines, grants the port in bursts with round-robin fairness and a bounded tenure, and returns qualified read data to whichever requester issued the read. It sits between the CPU's address mux and the memory instance, so the loader can fill or inspect memory without halting the clock.

---
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-bounded sharing of the single memory port between CPU (port 0) and loader/DMA (port 1)
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              last0,
    input  logic              last1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);
    localparam int CW = $clog2(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, nxt;
    logic            last_owner;
    logic [CW-1:0]   beat_cnt;
    logic            beat_max, rel0, rel1;

    assign gnt0     = (state == OWN0) & req0;
    assign gnt1     = (state == OWN1) & req1;
    assign mem_A    = (state == OWN1) ? addr1 : addr0;
    assign mem_WD   = (state == OWN1) ? wdata1 : wdata0;
    assign mem_WE   = (gnt0 & we0) | (gnt1 & we1);
    assign rdata    = mem_RD;
    assign beat_max = beat_cnt == CW'(MAX_BURST - 1);

    // The tenure limit only bites when the other port is waiting; otherwise the count just wraps.
    always_comb begin
        rel0 = ~req0 | (gnt0 & (last0 | (beat_max & req1)));
        rel1 = ~req1 | (gnt1 & (last1 | (beat_max & req0)));
        nxt  = state;
        nxt  = (state == OWN0) ? (rel0 ? (req1 ? OWN1 : IDLE) : OWN0) :
               (state == OWN1) ? (rel1 ? (req0 ? OWN0 : IDLE) : OWN1) :
               (req0 & req1)   ? (last_owner ? OWN0 : OWN1) :
               req0 ? OWN0 : req1 ? OWN1 : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            state   <= nxt;
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (nxt != state && nxt != IDLE) begin
                last_owner <= nxt == OWN1;
                beat_cnt   <= '0;
            end else if (gnt0 | gnt1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random traffic against a tenure-level model
module tb_mem_port_arbiter;
    localparam int MB = 8;

    logic        clk, reset;
    logic        req0, req1, we0, we1, last0, last1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .last0(last0), .last1(last1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_RD(mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram  [256];
    logic [31:0] mmem [256];

    always @(posedge clk) begin
        if (mem_WE) ram[mem_A[7:0]] <= mem_WD;
        mem_RD <= ram[mem_A[7:0]];
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, beats in this tenure, last winner
    int          own, beats, lastw;
    logic        erv0, erv1;
    logic [31:0] erd;

    task automatic model_check;
        logic eg0, eg1, ewe;
        logic [31:0] ea, ewd;
        eg0 = own == 0 && req0;
        eg1 = own == 1 && req1;
        ea  = own == 1 ? addr1 : addr0;
        ewd = own == 1 ? wdata1 : wdata0;
        ewe = (eg0 && we0) || (eg1 && we1);
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("mem_WE", 32'(mem_WE), 32'(ewe));
        chk("mem_A", mem_A, ea);
        if (ewe) chk("mem_WD", mem_WD, ewd);
        chk("rvalid0", 32'(rvalid0), 32'(erv0));
        chk("rvalid1", 32'(rvalid1), 32'(erv1));
        if (erv0 || erv1) chk("rdata", rdata, erd);
    endtask

    task automatic model_update;
        logic eg0, eg1, mine, other, lst;
        logic [31:0] ea, ewd;
        eg0  = own == 0 && req0;
        eg1  = own == 1 && req1;
        ea   = own == 1 ? addr1 : addr0;
        ewd  = own == 1 ? wdata1 : wdata0;
        erv0 = eg0 && !we0;
        erv1 = eg1 && !we1;
        erd  = mmem[ea[7:0]];
        if ((eg0 && we0) || (eg1 && we1)) mmem[ea[7:0]] = ewd;
        if (own < 0) begin
            if (req0 && req1) own = 1 - lastw;
            else if (req0) own = 0;
            else if (req1) own = 1;
            if (own >= 0) begin lastw = own; beats = 0; end
        end else begin
            mine  = own == 0 ? req0 : req1;
            other = own == 0 ? req1 : req0;
            lst   = own == 0 ? last0 : last1;
            if (!mine || lst || ((beats % MB) == MB - 1 && other)) begin
                if (other) begin own = 1 - own; lastw = own; beats = 0; end
                else own = -1;
            end else beats++;
        end
    endtask

    logic        obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1;
    logic [31:0] obs_a, obs_rd;

    task automatic tick;
        @(negedge clk);
        model_check;
        obs_g0 = gnt0; obs_g1 = gnt1; obs_we = mem_WE;
        obs_rv0 = rvalid0; obs_rv1 = rvalid1; obs_a = mem_A; obs_rd = rdata;
        @(posedge clk);
        model_update;
        #1;
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic w0, input logic w1,
                          input logic l0, input logic l1, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; last0 = l0; last1 = l1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #1;
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_mem_WE", 32'(mem_WE), 0);
        chk("rst_mem_A", mem_A, addr0);
        own = -1; lastw = 1; beats = 0; erv0 = 0; erv1 = 0; erd = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // r0 r1 w0 w1 l0 l1 | g0 g1 we rv0 rv1 sel1
    typedef struct packed {
        logic r0, r1, w0, w1, l0, l1, g0, g1, we, rv0, rv1, sel1;
    } vec_t;
    vec_t tbl [12];

    int n0, n1, g0b, cyc, c1, c0r, gcnt;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = {24'hA5C3E1, i[7:0]};
            mmem[i] = {24'hA5C3E1, i[7:0]};
        end
        tbl[0]  = 12'b110010_000000;
        tbl[1]  = 12'b110010_100000;
        tbl[2]  = 12'b010100_011101;
        tbl[3]  = 12'b010101_011001;
        tbl[4]  = 12'b110000_000000;
        tbl[5]  = 12'b010000_000000;
        tbl[6]  = 12'b010001_010001;
        tbl[7]  = 12'b000000_000010;
        tbl[8]  = 12'b010000_000000;
        tbl[9]  = 12'b110000_010001;
        tbl[10] = 12'b100000_000011;
        tbl[11] = 12'b100010_100000;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h10, 32'h20, 0, 0);
        #1;
        do_reset;

        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].l0, tbl[i].l1,
                   32'h10, 32'h20, 32'h1111_0000 + i, 32'h2222_0000 + i);
            tick;
            chk($sformatf("vec%0d", i),
                32'({obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1, obs_a == 32'h20}),
                32'(tbl[i][5:0]));
        end

        // Single read of 0x10 from idle
        do_reset;
        set_in(1, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0);
        tick;
        chk("rd_idle_gnt0", 32'(obs_g0), 0);
        tick;
        chk("rd_gnt0", 32'(obs_g0), 1);
        chk("rd_mem_A", obs_a, 32'h10);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("rd_rvalid0", 32'(obs_rv0), 1);
        chk("rd_rdata", obs_rd, 32'hA5C3E110);

        // Burst fairness: 12-beat port-0 read against a waiting port 1
        do_reset;
        n0 = 12; n1 = 1; g0b = 0; cyc = 0; c1 = -1; c0r = -1;
        while ((n0 > 0 || n1 > 0) && cyc < 60) begin
            set_in(n0 > 0, n1 > 0, 0, 0, n0 == 1, n1 == 1, 32'h100 + n0, 32'h200, 0, 0);
            tick;
            if (obs_g0) begin
                n0--;
                if (c1 < 0) g0b++;
                else if (c0r < 0) c0r = cyc;
            end
            if (obs_g1) begin n1--; c1 = cyc; end
            cyc++;
        end
        chk("burst_done", 32'(n0 + n1), 0);
        chk("burst_g0_before_g1", 32'(g0b), 8);
        chk("burst_resume_gap", 32'(c0r - c1), 1);

        // Unbounded tenure: 20 beats, port 1 silent
        do_reset;
        n0 = 20; cyc = 0; gcnt = 0;
        while (n0 > 0 && cyc < 60) begin
            set_in(1, 0, 0, 0, n0 == 1, 0, 32'h300 + n0, 0, 0, 0);
            tick;
            if (obs_g0) begin n0--; gcnt++; end
            cyc++;
        end
        chk("long_cycles", 32'(cyc), 21);
        chk("long_beats", 32'(gcnt), 20);

        // Write passthrough from port 1, read back on port 0
        do_reset;
        set_in(0, 1, 0, 1, 0, 1, 0, 32'h40, 0, 32'hDEADBEEF);
        tick;
        chk("wr_idle_we", 32'(obs_we), 0);
        tick;
        chk("wr_gnt1", 32'(obs_g1), 1);
        chk("wr_we", 32'(obs_we), 1);
        chk("wr_mem_A", obs_a, 32'h40);
        set_in(1, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0);
        tick;
        chk("wr_no_rvalid1", 32'(obs_rv1), 0);
        chk("wr_single_we", 32'(obs_we), 0);
        tick;
        chk("rb_gnt0", 32'(obs_g0), 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("rb_rvalid0", 32'(obs_rv0), 1);
        chk("rb_rdata", obs_rd, 32'hDEADBEEF);

        // Reset asserted mid-burst
        set_in(1, 0, 0, 0, 0, 0, 32'h50, 0, 0, 0);
        tick;
        tick;
        chk("mid_gnt0", 32'(gnt0), 1);
        do_reset;

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                   $urandom, $urandom, $urandom, $urandom);
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
